nibble_parity_tx: RTL and testbench

Serial transmitter for 4-bit words with even parity: accepts a parallel data word over a valid/ready handshake, frames it, and shifts it out on a single line. Frame order: start bit, data LSB-first, even-parity bit, stop bit. It is the sending end for the parity-checked serial links in the ch3/ch5 exercises, and the matching serial receiver/checker is built against this frame format. The parity bit is the XOR of all data bits, so the line always carries an even number of ones across data+parity.

---
 rtl/nibble_parity_tx.sv | 107 ++++++++++
 tb/tb_nibble_parity_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nibble_parity_tx.sv
`default_nettype none
// ============================================================================
// Module  : nibble_parity_tx
// Brief   : Serial transmitter: start, DATA_W bits LSB-first, even parity, stop.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_parity_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] Data,
  input  logic              Load,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy
);

  localparam int TIMER_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int INDEX_W = $clog2(DATA_W + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CYCLES - 1);
  localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                bit_done;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      index_q  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_done = (timer_q == TIMER_LAST);
    timer_d  = bit_done ? '0 : timer_q + TIMER_W'(1);

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (Load) begin
          shift_d  = Data;
          parity_d = ^Data;
          index_d  = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          index_d = index_q + INDEX_W'(1);
          if (index_q == INDEX_LAST) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so Load/Data never reach them combinationally.
  always_comb begin
    Ready = (state_q == S_IDLE);
    Busy  = ~Ready;
    case (state_q)
      S_START:  Tx = 1'b0;
      S_DATA:   Tx = shift_q[0];
      S_PARITY: Tx = parity_q;
      default:  Tx = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_parity_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_parity_tx
// Brief   : Directed self-checking bench for nibble_parity_tx (4/4 and 8/1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_parity_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_data;
  logic       a_load;
  logic       a_ready, a_tx, a_busy;
  logic [7:0] b_data;
  logic       b_load;
  logic       b_ready, b_tx, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nibble_parity_tx #(.DATA_W(4), .BIT_CYCLES(4)) u_dut_a (
    .Clock(clk), .Reset_b(rst_n), .Data(a_data), .Load(a_load),
    .Ready(a_ready), .Tx(a_tx), .Busy(a_busy)
  );

  nibble_parity_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut_b (
    .Clock(clk), .Reset_b(rst_n), .Data(b_data), .Load(b_load),
    .Ready(b_ready), .Tx(b_tx), .Busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after the accepting edge; exp holds slot values left-aligned.
  // pulse_at >= 0 drives a Load pulse carrying pulse_data into dut a mid-frame.
  task automatic check_frame(input string tag, input int which, input int nslots,
                             input int bc, input logic [0:10] exp,
                             input int pulse_at, input logic [3:0] pulse_data);
    int ready_low = 0;
    int ones = 0;
    int cyc = 0;
    logic tx, rdy;
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < bc; c++) begin
        tx  = (which == 0) ? a_tx : b_tx;
        rdy = (which == 0) ? a_ready : b_ready;
        check($sformatf("%s slot%0d cyc%0d tx", tag, s, c), {31'd0, tx}, {31'd0, exp[s]});
        if (!rdy) ready_low++;
        if (c == bc / 2 && s >= 1 && s <= nslots - 2) ones += int'(tx);
        if (cyc == pulse_at) begin
          a_data = pulse_data;
          a_load = 1'b1;
        end else if (pulse_at >= 0 && cyc == pulse_at + 1) begin
          a_load = 1'b0;
        end
        cyc++;
        tick();
      end
    end
    check({tag, " ready_low_clocks"}, ready_low, nslots * bc);
    check({tag, " data+parity ones even"}, ones % 2, 0);
    rdy = (which == 0) ? a_ready : b_ready;
    check({tag, " ready after frame"}, {31'd0, rdy}, 32'd1);
  endtask

  task automatic send_a(input string tag, input logic [3:0] d, input logic [0:6] exp,
                        input int pulse_at, input logic [3:0] pulse_data);
    a_data = d;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    check({tag, " busy at accept"}, {31'd0, a_busy}, 32'd1);
    check_frame(tag, 0, 7, 4, {exp, 4'b0000}, pulse_at, pulse_data);
  endtask

  initial begin
    int bad;
    rst_n  = 1'b0;
    a_data = '0; a_load = 1'b0;
    b_data = '0; b_load = 1'b0;
    #2;
    check("reset tx", {31'd0, a_tx}, 32'd1);
    check("reset ready", {31'd0, a_ready}, 32'd1);
    check("reset busy", {31'd0, a_busy}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    send_a("f1011", 4'b1011, 7'b0110111, -1, 4'b0000);
    send_a("f0000", 4'b0000, 7'b0000001, -1, 4'b0000);
    send_a("f0110", 4'b0110, 7'b0011001, -1, 4'b0000);
    send_a("f0001_ign", 4'b0001, 7'b0100011, 10, 4'b1110);

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
      tick();
    end
    check("no frame after ignored load", bad, 0);

    // Back-to-back with Load held high; Data changes mid-frame are ignored.
    a_data = 4'b1000;
    a_load = 1'b1;
    tick();
    a_data = 4'b0111;
    check_frame("b2b first", 0, 7, 4, {7'b0000111, 4'b0000}, -1, 4'b0000);
    check("b2b idle tx", {31'd0, a_tx}, 32'd1);
    check("b2b idle busy", {31'd0, a_busy}, 32'd0);
    tick();
    a_load = 1'b0;
    check("b2b second busy", {31'd0, a_busy}, 32'd1);
    check_frame("b2b second", 0, 7, 4, {7'b0111011, 4'b0000}, -1, 4'b0000);

    // Asynchronous reset during the 2nd data bit.
    a_data = 4'b1111;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre-reset busy", {31'd0, a_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset tx", {31'd0, a_tx}, 32'd1);
    check("async reset ready", {31'd0, a_ready}, 32'd1);
    check("async reset busy", {31'd0, a_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_tx !== 1'b1) bad++;
      tick();
    end
    check("idle after reset", bad, 0);

    // Parameter sweep instance: 8 data bits, one clock per bit.
    b_data = 8'hA5;
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    check_frame("sweep A5", 1, 11, 1, 11'b01010010101, -1, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
